// File: rtl/aes_vector_player_if.sv
// rtl/aes_vector_player_if.sv - Vector/result handshake between the player and the AES core under test
interface aes_vector_player_if #(
    parameter int DATA_W = 128
);
    logic              dut_valid;
    logic              dut_ready;
    logic [DATA_W-1:0] dut_key;
    logic [DATA_W-1:0] dut_pt;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;

    modport master (
        output dut_valid, dut_key, dut_pt,
        input  dut_ready, res_valid, res_data
    );

    modport slave (
        input  dut_valid, dut_key, dut_pt,
        output dut_ready, res_valid, res_data
    );
endinterface

// File: rtl/aes_vector_player.sv
// rtl/aes_vector_player.sv - Replays stored AES key/plaintext vectors into a core and scores its ciphertexts
module aes_vector_player #(
    parameter  int DATA_W  = 128,
    parameter  int DEPTH   = 100,
    parameter  int TIMEOUT = 1024,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int CNT_W   = ADDR_W + 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_en,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [3*DATA_W-1:0]   ld_data,
    input  logic                  start,
    input  logic                  loop_mode,
    input  logic                  stop,
    aes_vector_player_if.master   dut_if,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic [ADDR_W-1:0]     first_fail
);
    // Wait counter must be able to hold TIMEOUT itself: WAIT lasts TIMEOUT+1 cycles before aborting.
    localparam int                TW         = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [TW-1:0]     WAIT_LIMIT = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state;
    logic [3*DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]   addr;
    logic                loop_lat;
    logic                stop_pend;
    logic [TW-1:0]       wait_cnt;
    logic [DATA_W-1:0]   exp_data;
    logic                idle_like;
    logic                no_fail_yet;
    logic                keep_looping;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Memory is read asynchronously so a vector written in the start cycle is what the run sees;
    // it cannot change while busy, which keeps dut_key/dut_pt stable during ISSUE.
    assign idle_like      = (state == IDLE) || (state == DONE);
    assign dut_if.dut_key = mem[addr][3*DATA_W-1 -: DATA_W];
    assign dut_if.dut_pt  = mem[addr][2*DATA_W-1 -: DATA_W];
    assign exp_data       = mem[addr][DATA_W-1:0];
    assign no_fail_yet    = (fail_cnt == '0);
    assign keep_looping   = loop_lat && !stop_pend && !stop;

    // Vector memory load port, only open while no run is active; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en && idle_like && (32'(ld_addr) < DEPTH)) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Run sequencer: issue each vector, wait for its result or a timeout, score it, advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            addr             <= '0;
            loop_lat         <= 1'b0;
            stop_pend        <= 1'b0;
            wait_cnt         <= '0;
            dut_if.dut_valid <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            timeout          <= 1'b0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= ISSUE;
                        addr             <= '0;
                        loop_lat         <= loop_mode;
                        stop_pend        <= 1'b0;
                        dut_if.dut_valid <= 1'b1;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        timeout          <= 1'b0;
                        pass_cnt         <= '0;
                        fail_cnt         <= '0;
                        first_fail       <= '0;
                    end
                end
                ISSUE: begin
                    if (loop_lat && stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (dut_if.dut_ready) begin
                        state            <= WAIT;
                        dut_if.dut_valid <= 1'b0;
                        wait_cnt         <= '0;
                    end
                end
                WAIT: begin
                    if (loop_lat && stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (dut_if.res_valid) begin
                        if (dut_if.res_data == exp_data) begin
                            pass_cnt <= sat_inc(pass_cnt);
                        end else begin
                            fail_cnt <= sat_inc(fail_cnt);
                            if (no_fail_yet) begin
                                first_fail <= addr;
                            end
                        end
                        if (addr != LAST_ADDR) begin
                            addr             <= addr + ADDR_W'(1);
                            state            <= ISSUE;
                            dut_if.dut_valid <= 1'b1;
                        end else if (keep_looping) begin
                            addr             <= '0;
                            state            <= ISSUE;
                            dut_if.dut_valid <= 1'b1;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        // The core went silent: score it as a failure and abandon the run.
                        timeout  <= 1'b1;
                        fail_cnt <= sat_inc(fail_cnt);
                        if (no_fail_yet) begin
                            first_fail <= addr;
                        end
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: begin
                    state            <= IDLE;
                    dut_if.dut_valid <= 1'b0;
                    busy             <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_vector_player.sv
// tb/tb_aes_vector_player.sv - Self-checking bench for aes_vector_player
module tb_aes_vector_player;
    localparam int DATA_W  = 128;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int ADDR_W  = 2;
    localparam int CNT_W   = 10;

    logic                clk;
    logic                reset;
    logic                ld_en;
    logic [ADDR_W-1:0]   ld_addr;
    logic [3*DATA_W-1:0] ld_data;
    logic                start;
    logic                loop_mode;
    logic                stop;
    logic                busy;
    logic                done;
    logic                timeout;
    logic [CNT_W-1:0]    pass_cnt;
    logic [CNT_W-1:0]    fail_cnt;
    logic [ADDR_W-1:0]   first_fail;

    aes_vector_player_if #(.DATA_W(DATA_W)) dif ();

    aes_vector_player #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .loop_mode(loop_mode), .stop(stop), .dut_if(dif),
        .busy(busy), .done(done), .timeout(timeout),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail(first_fail)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [127:0] gk [4];
    logic [127:0] gp [4];
    logic [127:0] gc [4];
    logic [127:0] mk [4];
    logic [127:0] mp [4];
    logic [127:0] me [4];

    // Responder controls and observations
    bit           rand_ready = 0;
    bit           rand_lat   = 0;
    int           ready_hold = 0;
    int           resp_budget = 1000000;
    int           acc_count = 0;
    int           res_count = 0;
    int           acc_cyc = 0;
    bit           pending = 0;
    int           lat_left = 0;
    logic [127:0] pend_res;

    typedef struct {
        logic [3:0] corrupt;
        int         e_pass;
        int         e_fail;
        int         e_ff;
    } tvec_t;
    tvec_t tbl [5];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural AES core: known vectors give their golden ciphertext, anything else key^pt.
    function automatic logic [127:0] model_resp(input logic [127:0] key, input logic [127:0] pt);
        for (int i = 0; i < 4; i++) begin
            if (gk[i] == key && gp[i] == pt) return gc[i];
        end
        return key ^ pt;
    endfunction

    initial begin
        dif.dut_ready = 0;
        dif.res_valid = 0;
        dif.res_data  = '0;
        forever begin
            @(negedge clk);
            dif.res_valid = 0;
            if (!reset) begin
                pending = 0;
            end else if (pending) begin
                if (lat_left == 0) begin
                    dif.res_valid = 1;
                    dif.res_data  = pend_res;
                    pending = 0;
                    res_count++;
                end else begin
                    lat_left--;
                end
            end
            if (ready_hold > 0) begin
                dif.dut_ready = 0;
                ready_hold--;
            end else begin
                dif.dut_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (reset && dif.dut_valid && dif.dut_ready) begin
                acc_count++;
                acc_cyc = cyc + 1;
                if (resp_budget > 0) begin
                    resp_budget--;
                    pending  = 1;
                    pend_res = model_resp(dif.dut_key, dif.dut_pt);
                    lat_left = rand_lat ? int'($urandom_range(0, 3)) : 0;
                end
            end
        end
    end

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_vec(input int a, input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
        @(negedge clk);
        ld_en   = 1;
        ld_addr = ADDR_W'(a);
        ld_data = {k, p, e};
        @(negedge clk);
        ld_en = 0;
        mk[a] = k;
        mp[a] = p;
        me[a] = e;
    endtask

    task automatic load_golden();
        for (int i = 0; i < 4; i++) load_vec(i, gk[i], gp[i], gc[i]);
    endtask

    task automatic start_run(input bit lm);
        @(negedge clk);
        start = 1;
        loop_mode = lm;
        @(negedge clk);
        start = 0;
        loop_mode = 0;
        chk_i("start_latency", int'(dif.dut_valid), 1);
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles (got 0 expected 1)", name, bound);
        end
    endtask

    task automatic chk_run(input string name, input int ep, input int ef, input int eff, input int eto);
        chk_i({name, "_pass"}, int'(pass_cnt), ep);
        chk_i({name, "_fail"}, int'(fail_cnt), ef);
        chk_i({name, "_first_fail"}, int'(first_fail), eff);
        chk_i({name, "_timeout"}, int'(timeout), eto);
        chk_i({name, "_done"}, int'(done), 1);
        chk_i({name, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int base, n, seen, prev, ep, eff;
        bit lm;
        logic [127:0] pt0;

        gk[0] = 128'h000102030405060708090a0b0c0d0e0f;
        gp[0] = 128'h00112233445566778899aabbccddeeff;
        gc[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        gk[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        gp[1] = 128'h3243f6a8885a308d313198a2e0370734;
        gc[1] = 128'h3925841d02dc09fbdc118597196a0b32;
        gk[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        gp[2] = 128'h6bc1bee22e409f96e93d7e117393172a;
        gc[2] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        gk[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        gp[3] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        gc[3] = 128'hf5d3d58503b9699de785895a96fdbaaf;

        tbl[0] = '{4'b0000, 4, 0, 0};
        tbl[1] = '{4'b0100, 3, 1, 2};
        tbl[2] = '{4'b1010, 2, 2, 1};
        tbl[3] = '{4'b1111, 0, 4, 0};
        tbl[4] = '{4'b1000, 3, 1, 3};

        reset = 0; ld_en = 0; ld_addr = '0; ld_data = '0; start = 0; loop_mode = 0; stop = 0;
        repeat (3) @(negedge clk);
        chk_i("rst_dut_valid", int'(dif.dut_valid), 0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_done", int'(done), 0);
        chk_i("rst_timeout", int'(timeout), 0);
        chk_i("rst_pass", int'(pass_cnt), 0);
        chk_i("rst_fail", int'(fail_cnt), 0);
        chk_i("rst_first_fail", int'(first_fail), 0);
        reset = 1;

        // Table of one-pass runs with selected expected values corrupted
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 4; i++) load_vec(i, gk[i], gp[i], tbl[t].corrupt[i] ? (gc[i] ^ 128'h1) : gc[i]);
            start_run(0);
            wait_done($sformatf("tbl%0d_wait", t), 2000);
            chk_run($sformatf("tbl%0d", t), tbl[t].e_pass, tbl[t].e_fail, tbl[t].e_ff, 0);
        end

        // dut_ready held low: vector must stay presented and unaccepted
        load_golden();
        base = acc_count;
        @(negedge clk);
        ready_hold = 9;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        pt0 = dif.dut_pt;
        for (int k = 0; k < 7; k++) begin
            chk_i($sformatf("hold_valid_%0d", k), int'(dif.dut_valid), 1);
            chk_w($sformatf("hold_pt_%0d", k), dif.dut_pt, gp[0]);
            chk_i($sformatf("hold_acc_%0d", k), acc_count - base, 0);
            @(negedge clk);
        end
        wait_done("hold_wait", 2000);
        chk_i("hold_acc_total", acc_count - base, 4);
        chk_run("hold", 4, 0, 0, 0);

        // start and ld_en while busy are ignored
        base = acc_count;
        start_run(0);
        n = 0;
        while (acc_count == base && n < 100) begin @(negedge clk); n++; end
        chk_i("busy_accepted", acc_count - base, 1);
        start = 1; ld_en = 1; ld_addr = 2'd3; ld_data = {gk[3], gp[3], ~gc[3]};
        @(negedge clk);
        start = 0; ld_en = 0;
        wait_done("busy_wait", 2000);
        chk_i("busy_acc_total", acc_count - base, 4);
        chk_run("busy", 4, 0, 0, 0);

        // Write and start in the same cycle: the run must see the new data
        @(negedge clk);
        ld_en = 1; ld_addr = 2'd0; ld_data = {gk[0], gp[0], gc[0] ^ 128'h1}; start = 1;
        @(negedge clk);
        ld_en = 0; start = 0;
        wait_done("ldstart_wait", 2000);
        chk_run("ldstart", 3, 1, 0, 0);
        load_vec(0, gk[0], gp[0], gc[0]);

        // Silent core: abort on timeout 17 cycles after acceptance
        resp_budget = 0;
        start_run(0);
        wait_done("to_wait", 200);
        chk_i("to_latency", cyc - acc_cyc, TIMEOUT + 1);
        chk_run("to", 0, 1, 0, 1);
        resp_budget = 1000000;

        // Loop mode, stop pulsed while address 1 of pass 2 is presented
        start_run(1);
        seen = 0; prev = 0; n = 0;
        while (seen < 2 && n < 500) begin
            @(negedge clk);
            n++;
            if (dif.dut_valid && dif.dut_pt == gp[1] && !prev) seen++;
            prev = (dif.dut_valid && dif.dut_pt == gp[1]) ? 1 : 0;
        end
        chk_i("loop_reached_pass2", seen, 2);
        stop = 1;
        @(negedge clk);
        stop = 0;
        wait_done("loop_wait", 2000);
        chk_run("loop", 8, 0, 0, 0);

        // Reset during WAIT after two results, then rerun from retained memory
        resp_budget = 2;
        base = acc_count;
        start_run(0);
        n = 0;
        while (acc_count - base < 3 && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk_i("rstmid_busy_before", int'(busy), 1);
        chk_i("rstmid_pass_before", int'(pass_cnt), 2);
        reset = 0;
        @(negedge clk);
        chk_i("rstmid_dut_valid", int'(dif.dut_valid), 0);
        chk_i("rstmid_busy", int'(busy), 0);
        chk_i("rstmid_pass", int'(pass_cnt), 0);
        chk_i("rstmid_done", int'(done), 0);
        @(negedge clk);
        reset = 1;
        resp_budget = 1000000;
        start_run(0);
        wait_done("rstmid_wait", 2000);
        chk_run("rstmid", 4, 0, 0, 0);

        // Randomised vectors, ready and latency against the counting reference
        rand_ready = 1;
        rand_lat = 1;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 4; i++) begin
                logic [127:0] k, p, e;
                k = {$urandom, $urandom, $urandom, $urandom};
                p = {$urandom, $urandom, $urandom, $urandom};
                e = ($urandom_range(0, 1) == 1) ? (k ^ p) : {$urandom, $urandom, $urandom, $urandom};
                load_vec(i, k, p, e);
            end
            ep = 0; eff = -1;
            for (int i = 0; i < 4; i++) begin
                if (model_resp(mk[i], mp[i]) == me[i]) ep++;
                else if (eff < 0) eff = i;
            end
            if (eff < 0) eff = 0;
            lm = 1'($urandom_range(0, 1));
            start_run(lm);
            if (lm) begin
                stop = 1;
                @(negedge clk);
                stop = 0;
            end
            wait_done($sformatf("rnd%0d_wait", it), 2000);
            chk_run($sformatf("rnd%0d", it), ep, 4 - ep, eff, 0);
        end

        // Loop long enough to saturate pass_cnt
        load_golden();
        base = res_count;
        start_run(1);
        n = 0;
        while (res_count - base < 1030 && n < 20000) begin @(negedge clk); n++; end
        chk_i("sat_results_reached", (res_count - base >= 1030) ? 1 : 0, 1);
        stop = 1;
        @(negedge clk);
        stop = 0;
        wait_done("sat_wait", 500);
        chk_run("sat", 1023, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
